// File: rtl/tail_light_seq.sv
// Turn / hazard / brake tail-light sequencer for NLAMP lamps per side.
// Sweeps fill outward one lamp per STEP_CYC clocks; brake overlays idle sides.
module tail_light_seq #(
  parameter int NLAMP    = 3,
  parameter int STEP_CYC = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             left,
  input  logic             right,
  input  logic             hazard,
  input  logic             brake,
  output logic [NLAMP-1:0] lamp_l,
  output logic [NLAMP-1:0] lamp_r,
  output logic             busy
);

  localparam int SW = $clog2(NLAMP + 1);
  localparam int PW = $clog2(STEP_CYC + 1);

  localparam logic [PW-1:0] PLAST = PW'(STEP_CYC - 1);
  localparam logic [SW-1:0] SLAST = SW'(NLAMP);
  localparam logic [SW-1:0] SONE  = SW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LSEQ = 2'd1,
    RSEQ = 2'd2,
    HAZ  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   step_q, step_d;
  logic            phase_q, phase_d;
  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic            tick;
  logic [NLAMP-1:0] sweep;

  assign tick = (pcnt_q == PLAST);

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    phase_d = phase_q;
    pcnt_d  = tick ? '0 : pcnt_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        pcnt_d  = '0;
        step_d  = SONE;
        phase_d = 1'b0;
        if (hazard) begin
          state_d = HAZ;
          phase_d = 1'b1;
        end else if (left) begin
          state_d = LSEQ;
        end else if (right) begin
          state_d = RSEQ;
        end
      end
      LSEQ, RSEQ: begin
        if (hazard) begin
          state_d = HAZ;
          phase_d = 1'b1;
          pcnt_d  = '0;
        end else if (tick) begin
          if (step_q == SLAST) begin
            state_d = IDLE;
            step_d  = SONE;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
      end
      HAZ: begin
        if (tick) begin
          if (hazard) begin
            phase_d = ~phase_q;
          end else begin
            state_d = IDLE;
            phase_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        step_d  = SONE;
        phase_d = 1'b0;
        pcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      step_q  <= SONE;
      phase_q <= 1'b0;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      phase_q <= phase_d;
      pcnt_q  <= pcnt_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NLAMP; i++) begin
      sweep[i] = (SW'(i) < step_q);
    end
  end

  // Reset gates the drivers directly so lamps go dark without a clock.
  always_comb begin
    lamp_l = {NLAMP{brake}};
    lamp_r = {NLAMP{brake}};
    busy   = (state_q != IDLE);
    unique case (state_q)
      LSEQ:    lamp_l = sweep;
      RSEQ:    lamp_r = sweep;
      HAZ: begin
        lamp_l = {NLAMP{phase_q}};
        lamp_r = {NLAMP{phase_q}};
      end
      default: ;
    endcase
    if (!reset) begin
      lamp_l = '0;
      lamp_r = '0;
      busy   = 1'b0;
    end
  end

endmodule

// File: tb/tb_tail_light_seq.sv
// Bench for tail_light_seq: four parameter sets on shared inputs,
// table rows queued as expectations and compared after each clock.
module tb_tail_light_seq;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic left = 1'b0, right = 1'b0, hazard = 1'b0, brake = 1'b0;

  logic [2:0] l0, r0, l1, r1, l2, r2;
  logic [4:0] l3, r3;
  logic       b0, b1, b2, b3;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  tail_light_seq #(.NLAMP(3), .STEP_CYC(1)) u0 (
    .clk(clk), .reset(reset), .left(left), .right(right),
    .hazard(hazard), .brake(brake),
    .lamp_l(l0), .lamp_r(r0), .busy(b0));

  tail_light_seq #(.NLAMP(3), .STEP_CYC(4)) u1 (
    .clk(clk), .reset(reset), .left(left), .right(right),
    .hazard(hazard), .brake(brake),
    .lamp_l(l1), .lamp_r(r1), .busy(b1));

  tail_light_seq #(.NLAMP(3), .STEP_CYC(2)) u2 (
    .clk(clk), .reset(reset), .left(left), .right(right),
    .hazard(hazard), .brake(brake),
    .lamp_l(l2), .lamp_r(r2), .busy(b2));

  tail_light_seq #(.NLAMP(5), .STEP_CYC(3)) u3 (
    .clk(clk), .reset(reset), .left(left), .right(right),
    .hazard(hazard), .brake(brake),
    .lamp_l(l3), .lamp_r(r3), .busy(b3));

  typedef struct {
    string      nm;
    logic       l, r, h, b;
    logic [4:0] el, er;
    logic       eb;
  } vec_t;

  vec_t vecs[$];
  vec_t expq[$];

  task automatic add(input string nm, input logic l, input logic r,
                     input logic h, input logic b, input logic [4:0] el,
                     input logic [4:0] er, input logic eb);
    vec_t v;
    v.nm = nm; v.l = l; v.r = r; v.h = h; v.b = b;
    v.el = el; v.er = er; v.eb = eb;
    vecs.push_back(v);
  endtask

  task automatic cmp(input int sel, input string nm, input logic [4:0] el,
                     input logic [4:0] er, input logic eb);
    logic [4:0] al, ar;
    logic       ab;
    case (sel)
      0:       begin al = {2'b0, l0}; ar = {2'b0, r0}; ab = b0; end
      1:       begin al = {2'b0, l1}; ar = {2'b0, r1}; ab = b1; end
      2:       begin al = {2'b0, l2}; ar = {2'b0, r2}; ab = b2; end
      default: begin al = l3; ar = r3; ab = b3; end
    endcase
    ntests++;
    if (al !== el || ar !== er || ab !== eb) begin
      nfail++;
      $display("FAIL %s (dut%0d): got l=%b r=%b busy=%b, want l=%b r=%b busy=%b",
               nm, sel, al, ar, ab, el, er, eb);
    end
  endtask

  task automatic run(input int sel);
    vec_t e;
    foreach (vecs[i]) begin
      @(negedge clk);
      left = vecs[i].l; right = vecs[i].r;
      hazard = vecs[i].h; brake = vecs[i].b;
      expq.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = expq.pop_front();
      cmp(sel, $sformatf("%s[%0d]", e.nm, i), e.el, e.er, e.eb);
    end
    vecs.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    left = 0; right = 0; hazard = 0; brake = 0;
    reset = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 4; s++) cmp(s, "reset", 5'd0, 5'd0, 1'b0);
    reset = 1'b1;
  endtask

  initial begin
    // held left sweep repeats with one idle clock between sweeps
    do_reset();
    for (int k = 0; k < 2; k++) begin
      add("held_left", 1, 0, 0, 0, 5'b001, 0, 1);
      add("held_left", 1, 0, 0, 0, 5'b011, 0, 1);
      add("held_left", 1, 0, 0, 0, 5'b111, 0, 1);
      add("held_left", 1, 0, 0, 0, 5'b000, 0, 0);
    end
    add("haz_prio", 1, 1, 1, 0, 5'b111, 5'b111, 1);
    run(0);

    // one-clock right pulse, four clocks per step
    do_reset();
    add("right_pulse", 0, 1, 0, 0, 0, 5'b001, 1);
    for (int k = 0; k < 3; k++) add("right_s1", 0, 0, 0, 0, 0, 5'b001, 1);
    for (int k = 0; k < 4; k++) add("right_s2", 0, 0, 0, 0, 0, 5'b011, 1);
    for (int k = 0; k < 4; k++) add("right_s3", 0, 0, 0, 0, 0, 5'b111, 1);
    add("right_done", 0, 0, 0, 0, 0, 0, 0);
    add("right_done", 0, 0, 0, 0, 0, 0, 0);
    run(1);

    // hazard aborts a sweep at step 2; release completes phase
    do_reset();
    add("sw_s1", 1, 0, 0, 0, 5'b001, 0, 1);
    add("sw_s1", 0, 0, 0, 0, 5'b001, 0, 1);
    add("sw_s2", 0, 0, 0, 0, 5'b011, 0, 1);
    add("haz_on", 0, 0, 1, 0, 5'b111, 5'b111, 1);
    add("haz_on", 0, 0, 1, 0, 5'b111, 5'b111, 1);
    add("haz_off", 0, 0, 1, 0, 5'b000, 5'b000, 1);
    add("haz_brk", 0, 0, 1, 1, 5'b000, 5'b000, 1);
    add("haz_on2", 0, 0, 1, 0, 5'b111, 5'b111, 1);
    add("haz_rel", 0, 0, 0, 0, 5'b111, 5'b111, 1);
    add("haz_idle", 0, 0, 0, 0, 5'b000, 5'b000, 0);
    add("idle_brk", 0, 0, 0, 1, 5'b111, 5'b111, 0);
    run(2);

    // brake is combinational in idle and overlays the non-sweeping side
    do_reset();
    @(negedge clk);
    brake = 1'b1;
    #1 cmp(0, "brake_now", 5'b111, 5'b111, 1'b0);
    brake = 1'b0;
    #1 cmp(0, "brake_rel", 5'b000, 5'b000, 1'b0);
    add("brk_sweep", 1, 0, 0, 1, 5'b001, 5'b111, 1);
    add("brk_sweep", 0, 0, 0, 1, 5'b011, 5'b111, 1);
    add("brk_sweep", 0, 0, 0, 1, 5'b111, 5'b111, 1);
    add("brk_idle", 0, 0, 0, 1, 5'b111, 5'b111, 0);
    add("brk_none", 0, 0, 0, 0, 5'b000, 5'b000, 0);
    run(0);

    // both requests favour left; async reset mid sweep
    do_reset();
    add("both_req", 1, 1, 0, 0, 5'b001, 0, 1);
    add("both_req", 0, 0, 0, 1, 5'b011, 5'b111, 1);
    run(0);
    #2 reset = 1'b0;
    #1 cmp(0, "async_rst", 5'b000, 5'b000, 1'b0);
    @(negedge clk);
    brake = 1'b0;
    reset = 1'b1;
    add("post_rst", 0, 0, 0, 0, 5'b000, 5'b000, 0);
    add("post_rst", 0, 0, 0, 1, 5'b111, 5'b111, 0);
    add("post_right", 0, 1, 0, 0, 5'b000, 5'b001, 1);
    run(0);

    // wide instance: five lamps, three clocks per step
    do_reset();
    add("wide_pulse", 1, 0, 0, 0, 5'b00001, 0, 1);
    add("wide_s1", 0, 0, 0, 0, 5'b00001, 0, 1);
    add("wide_s1", 0, 0, 0, 0, 5'b00001, 0, 1);
    for (int k = 0; k < 3; k++) add("wide_s2", 0, 0, 0, 0, 5'b00011, 0, 1);
    for (int k = 0; k < 3; k++) add("wide_s3", 0, 0, 0, 0, 5'b00111, 0, 1);
    for (int k = 0; k < 3; k++) add("wide_s4", 0, 0, 0, 0, 5'b01111, 0, 1);
    for (int k = 0; k < 3; k++) add("wide_s5", 0, 0, 0, 0, 5'b11111, 0, 1);
    add("wide_done", 0, 0, 0, 0, 5'b00000, 0, 0);
    run(3);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
